csr_counter_bank: RTL and testbench

Parametrised machine-mode counter bank for the CPU's CSR unit. It holds `mcycle`, `minstret`, `time` and NUM_HPM hardware performance counters, with `mcountinhibit`, `mcounteren` and `scounteren` gating. Reads are combinational. It raises an illegal-instruction exception on privilege or access violations. It sits beside the machine CSR file and answers the counter address ranges.

---
 rtl/csr_counter_bank.sv | 197 +++++++++++++++++++
 tb/tb_csr_counter_bank.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/csr_counter_bank.sv
// Machine-mode counter bank: mcycle, time, minstret and NUM_HPM hpm counters with enable/inhibit gating.
// Define CSR_COUNTER_OVF_EN to add hpm overflow bits, scountovf at 0xDA0 and a registered ovf_irq.
module csr_counter_bank #(
    parameter int XLEN    = 64,
    parameter int CNT_W   = 64,
    parameter int NUM_HPM = 4
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [1:0]                               priv_lvl,
    input  logic [11:0]                              csr_addr,
    input  logic                                     csr_re,
    input  logic                                     csr_we,
    input  logic [XLEN-1:0]                          csr_wdata,
    input  logic                                     instr_retired,
    input  logic                                     time_tick,
    input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0] hpm_event,
    output logic [XLEN-1:0]                          csr_rdata,
    output logic                                     csr_hit,
    output logic                                     exc_en,
    output logic [3:0]                               exc_code,
    output logic [XLEN-1:0]                          exc_val,
    output logic                                     ovf_irq
);
    localparam int          HPM_N    = (NUM_HPM > 0) ? NUM_HPM : 1;
    localparam logic [31:0] HPM_MASK = ((32'h1 << NUM_HPM) - 32'h1) << 3;
    localparam logic [31:0] EN_MASK  = HPM_MASK | 32'h7;
    localparam logic [31:0] INH_MASK = HPM_MASK | 32'h5;
    localparam logic [6:0]  M_CNT_PAGE = 7'h58;
    localparam logic [6:0]  U_CNT_PAGE = 7'h60;
    localparam logic [11:0] ADDR_MCOUNTEREN   = 12'h306;
    localparam logic [11:0] ADDR_SCOUNTEREN   = 12'h106;
    localparam logic [11:0] ADDR_MCOUNTINHIBIT = 12'h320;

    logic [CNT_W-1:0] cyc_q, cyc_d, tim_q, tim_d, ins_q, ins_d;
    logic [CNT_W-1:0] hpm_q [HPM_N];
    logic [CNT_W-1:0] hpm_d [HPM_N];
    logic [31:0]      men_q, men_d, sen_q, sen_d, inh_q, inh_d;
    logic [HPM_N-1:0] ovf_bits, wr_hpm, inc_hpm;

    logic [4:0]       cnt_k;
    logic             hpm_valid;
    logic             is_cnt, is_user, is_men, is_sen, is_inh, is_ovf;
    logic             allowed, read_only, access, illegal, wr_ok;
    logic [63:0]      wdata64, cnt_rd, rd_raw;
    logic [CNT_W-1:0] wcnt;
    logic             unused_bits;

    assign cnt_k       = csr_addr[4:0];
    assign hpm_valid   = (int'(cnt_k) >= 3) && (int'(cnt_k) < NUM_HPM + 3);
    assign wdata64     = 64'(csr_wdata);
    assign wcnt        = wdata64[CNT_W-1:0];
    assign unused_bits = ^{wdata64, hpm_event};

    // Counters live in two 32-entry pages (Bxx machine, Cxx user alias); B01 has no machine copy.
    always_comb begin
        is_cnt  = 1'b0;
        is_user = 1'b0;
        is_men  = 1'b0;
        is_sen  = 1'b0;
        is_inh  = 1'b0;
        is_ovf  = 1'b0;
        if (csr_addr[11:5] == M_CNT_PAGE) begin
            is_cnt = (cnt_k == 5'd0) || (cnt_k == 5'd2) || hpm_valid;
        end else if (csr_addr[11:5] == U_CNT_PAGE) begin
            is_cnt  = (cnt_k <= 5'd2) || hpm_valid;
            is_user = 1'b1;
        end else begin
            is_men = (csr_addr == ADDR_MCOUNTEREN);
            is_sen = (csr_addr == ADDR_SCOUNTEREN);
            is_inh = (csr_addr == ADDR_MCOUNTINHIBIT);
`ifdef CSR_COUNTER_OVF_EN
            is_ovf = (csr_addr == 12'hDA0);
`endif
        end
    end

    always_comb begin
        allowed   = (priv_lvl == 2'd3);
        read_only = 1'b0;
        if (is_user) begin
            read_only = 1'b1;
            if (priv_lvl == 2'd3) begin
                allowed = 1'b1;
            end else if (priv_lvl == 2'd0) begin
                allowed = men_q[cnt_k] & sen_q[cnt_k];
            end else begin
                allowed = men_q[cnt_k];
            end
        end else if (is_ovf) begin
            read_only = 1'b1;
            allowed   = (priv_lvl != 2'd0);
        end else if (is_sen) begin
            allowed = (priv_lvl != 2'd0);
        end
    end

    assign csr_hit  = is_cnt | is_men | is_sen | is_inh | is_ovf;
    assign access   = csr_re | csr_we;
    assign illegal  = access & (~csr_hit | ~allowed | (csr_we & read_only));
    assign wr_ok    = csr_we & ~illegal;
    assign exc_en   = illegal;
    assign exc_code = illegal ? 4'd2 : 4'd0;
    assign exc_val  = illegal ? {{(XLEN-12){1'b0}}, csr_addr} : '0;

    always_comb begin
        cnt_rd = '0;
        case (cnt_k)
            5'd0:    cnt_rd = 64'(cyc_q);
            5'd1:    cnt_rd = 64'(tim_q);
            5'd2:    cnt_rd = 64'(ins_q);
            default: begin
                for (int i = 0; i < HPM_N; i++) begin
                    if (int'(cnt_k) == i + 3) cnt_rd = 64'(hpm_q[i]);
                end
            end
        endcase
        rd_raw = '0;
        if (is_cnt)      rd_raw = cnt_rd;
        else if (is_men) rd_raw = {32'h0, men_q};
        else if (is_sen) rd_raw = {32'h0, sen_q};
        else if (is_inh) rd_raw = {32'h0, inh_q};
        else if (is_ovf) rd_raw = {32'h0, 32'(ovf_bits) << 3};
    end

    assign csr_rdata = illegal ? '0 : rd_raw[XLEN-1:0];

    // A write replaces the increment of its own cycle; inhibit is sampled from the registered value.
    always_comb begin
        cyc_d = cyc_q;
        if (wr_ok && is_cnt && cnt_k == 5'd0) cyc_d = wcnt;
        else if (!inh_q[0])                   cyc_d = cyc_q + CNT_W'(1);
        tim_d = tim_q + CNT_W'(time_tick);
        ins_d = ins_q;
        if (wr_ok && is_cnt && cnt_k == 5'd2)     ins_d = wcnt;
        else if (instr_retired && !inh_q[2])      ins_d = ins_q + CNT_W'(1);
        for (int i = 0; i < HPM_N; i++) begin
            wr_hpm[i]  = wr_ok && is_cnt && (int'(cnt_k) == i + 3);
            inc_hpm[i] = (i < NUM_HPM) && hpm_event[i] && !inh_q[3+i];
            hpm_d[i]   = wr_hpm[i] ? wcnt : hpm_q[i] + CNT_W'(inc_hpm[i]);
        end
        men_d = (wr_ok && is_men) ? (wdata64[31:0] & EN_MASK)  : men_q;
        sen_d = (wr_ok && is_sen) ? (wdata64[31:0] & EN_MASK)  : sen_q;
        inh_d = (wr_ok && is_inh) ? (wdata64[31:0] & INH_MASK) : inh_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q <= '0;
            tim_q <= '0;
            ins_q <= '0;
            men_q <= '0;
            sen_q <= '0;
            inh_q <= '0;
            for (int i = 0; i < HPM_N; i++) hpm_q[i] <= '0;
        end else begin
            cyc_q <= cyc_d;
            tim_q <= tim_d;
            ins_q <= ins_d;
            men_q <= men_d;
            sen_q <= sen_d;
            inh_q <= inh_d;
            for (int i = 0; i < HPM_N; i++) hpm_q[i] <= hpm_d[i];
        end
    end

`ifdef CSR_COUNTER_OVF_EN
    logic [HPM_N-1:0] ovf_q, ovf_d;
    logic             ovf_irq_q;

    // Only an increment past all-ones sets a bit; a machine write to that counter always clears it.
    always_comb begin
        for (int i = 0; i < HPM_N; i++) begin
            if (wr_hpm[i])                         ovf_d[i] = 1'b0;
            else if (inc_hpm[i] && (&hpm_q[i]))    ovf_d[i] = 1'b1;
            else                                   ovf_d[i] = ovf_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q     <= '0;
            ovf_irq_q <= 1'b0;
        end else begin
            ovf_q     <= ovf_d;
            ovf_irq_q <= |ovf_q;
        end
    end

    assign ovf_bits = ovf_q;
    assign ovf_irq  = ovf_irq_q;
`else
    assign ovf_bits = '0;
    assign ovf_irq  = 1'b0;
`endif

endmodule

// File: tb/tb_csr_counter_bank.sv
// Scoreboard bench for csr_counter_bank (CNT_W=16, NUM_HPM=2); covers the overflow block when CSR_COUNTER_OVF_EN is defined.
module tb_csr_counter_bank;
    localparam int XLEN    = 64;
    localparam int CNT_W   = 16;
    localparam int NUM_HPM = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [1:0]         priv_lvl;
    logic [11:0]        csr_addr;
    logic               csr_re, csr_we;
    logic [XLEN-1:0]    csr_wdata;
    logic               instr_retired, time_tick;
    logic [NUM_HPM-1:0] hpm_event;
    logic [XLEN-1:0]    csr_rdata;
    logic               csr_hit, exc_en;
    logic [3:0]         exc_code;
    logic [XLEN-1:0]    exc_val;
    logic               ovf_irq;

    typedef struct {
        string       name;
        logic [11:0] addr;
        bit          exc;
        bit          hit;
        bit          chkRd;
        logic [63:0] rd;
        bit          chkIrq;
        bit          irq;
    } exp_t;

    exp_t expq[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    csr_counter_bank #(.XLEN(XLEN), .CNT_W(CNT_W), .NUM_HPM(NUM_HPM)) dut (
        .clk(clk), .rst(rst), .priv_lvl(priv_lvl), .csr_addr(csr_addr),
        .csr_re(csr_re), .csr_we(csr_we), .csr_wdata(csr_wdata),
        .instr_retired(instr_retired), .time_tick(time_tick), .hpm_event(hpm_event),
        .csr_rdata(csr_rdata), .csr_hit(csr_hit), .exc_en(exc_en), .exc_code(exc_code),
        .exc_val(exc_val), .ovf_irq(ovf_irq)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // Monitor: every cycle with an access active consumes one expectation
    always @(negedge clk) begin
        if (csr_re || csr_we) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_access: got addr 0x%0h expected no access", csr_addr);
            end else begin
                e = expq.pop_front();
                checkOutput({e.name, "/exc_en"}, 64'(exc_en), 64'(e.exc));
                checkOutput({e.name, "/exc_code"}, 64'(exc_code), e.exc ? 64'd2 : 64'd0);
                checkOutput({e.name, "/exc_val"}, exc_val, e.exc ? 64'(e.addr) : 64'd0);
                checkOutput({e.name, "/hit"}, 64'(csr_hit), 64'(e.hit));
                if (e.chkRd)  checkOutput({e.name, "/rdata"}, csr_rdata, e.exc ? 64'd0 : e.rd);
                if (e.chkIrq) checkOutput({e.name, "/ovf_irq"}, 64'(ovf_irq), 64'(e.irq));
            end
        end
    end

    task automatic applyStimulus(input bit re, input bit we, input logic [11:0] addr,
                                 input logic [63:0] wd, input logic [1:0] priv, input string name,
                                 input bit expExc, input bit expHit, input bit chkRd,
                                 input logic [63:0] expRd, input bit chkIrq, input bit expIrq);
        exp_t x;
        x.name = name; x.addr = addr; x.exc = expExc; x.hit = expHit;
        x.chkRd = chkRd; x.rd = expRd; x.chkIrq = chkIrq; x.irq = expIrq;
        expq.push_back(x);
        csr_re = re; csr_we = we; csr_addr = addr; csr_wdata = wd; priv_lvl = priv;
        @(posedge clk);
        #1;
        csr_re = 1'b0; csr_we = 1'b0; csr_wdata = '0;
    endtask

    task automatic doRead(input logic [11:0] addr, input logic [1:0] priv, input string name,
                          input bit expExc, input bit expHit, input logic [63:0] expRd);
        applyStimulus(1'b1, 1'b0, addr, 64'd0, priv, name, expExc, expHit, 1'b1, expRd, 1'b0, 1'b0);
    endtask

    task automatic doReadIrq(input logic [11:0] addr, input logic [1:0] priv, input string name,
                             input logic [63:0] expRd, input bit expIrq);
        applyStimulus(1'b1, 1'b0, addr, 64'd0, priv, name, 1'b0, 1'b1, 1'b1, expRd, 1'b1, expIrq);
    endtask

    task automatic doWrite(input logic [11:0] addr, input logic [63:0] wd, input logic [1:0] priv,
                           input string name, input bit expExc, input bit expHit,
                           input bit chkRd, input logic [63:0] expRd);
        applyStimulus(1'b0, 1'b1, addr, wd, priv, name, expExc, expHit, chkRd, expRd, 1'b0, 1'b0);
    endtask

    task automatic pulseEvents(input int n, input bit ins, input bit tick, input logic [NUM_HPM-1:0] hpm);
        instr_retired = ins; time_tick = tick; hpm_event = hpm;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        instr_retired = 1'b0; time_tick = 1'b0; hpm_event = '0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no end of test expected finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; priv_lvl = 2'd3; csr_addr = '0; csr_re = 1'b0; csr_we = 1'b0;
        csr_wdata = '0; instr_retired = 1'b0; time_tick = 1'b0; hpm_event = '0;
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b0, 12'hB00, 64'd0, 2'd3, "rst_mcycle", 1'b0, 1'b1, 1'b1, 64'd0, 1'b1, 1'b0);
        doRead(12'h320, 2'd3, "rst_inhibit", 1'b0, 1'b1, 64'd0);
        doRead(12'h306, 2'd3, "rst_mcounteren", 1'b0, 1'b1, 64'd0);
        doRead(12'h106, 2'd3, "rst_scounteren", 1'b0, 1'b1, 64'd0);
        rst = 1'b0;

        pulseEvents(10, 1'b0, 1'b0, '0);
        doRead(12'hB00, 2'd3, "mcycle_10", 1'b0, 1'b1, 64'd10);
        doRead(12'hB02, 2'd3, "minstret_0", 1'b0, 1'b1, 64'd0);
        doRead(12'hB01, 2'd3, "b01_unmapped", 1'b1, 1'b0, 64'd0);
`ifdef CSR_COUNTER_OVF_EN
        doRead(12'hDA0, 2'd3, "scountovf_rst", 1'b0, 1'b1, 64'd0);
`else
        doRead(12'hDA0, 2'd3, "da0_absent", 1'b1, 1'b0, 64'd0);
`endif

        doWrite(12'h320, 64'hFFFF_FFFF, 2'd3, "inh_all", 1'b0, 1'b1, 1'b1, 64'd0);
        doRead(12'h320, 2'd3, "inh_mask", 1'b0, 1'b1, 64'h1D);
        doWrite(12'h320, 64'h4, 2'd3, "inh_ir", 1'b0, 1'b1, 1'b1, 64'h1D);
        pulseEvents(5, 1'b1, 1'b0, '0);
        doRead(12'hB02, 2'd3, "minstret_inhib", 1'b0, 1'b1, 64'd0);
        doWrite(12'h320, 64'h0, 2'd3, "inh_clr", 1'b0, 1'b1, 1'b1, 64'h4);
        pulseEvents(3, 1'b1, 1'b0, '0);
        doRead(12'hB02, 2'd3, "minstret_3", 1'b0, 1'b1, 64'd3);

        doWrite(12'h306, 64'hFFFF_FFFF, 2'd3, "men_all", 1'b0, 1'b1, 1'b1, 64'd0);
        doRead(12'h306, 2'd3, "men_mask", 1'b0, 1'b1, 64'h1F);
        doWrite(12'h306, 64'h1, 2'd3, "men_1", 1'b0, 1'b1, 1'b1, 64'h1F);
        doWrite(12'h306, 64'h7, 2'd1, "men_wr_s", 1'b1, 1'b1, 1'b1, 64'd0);
        doRead(12'h306, 2'd3, "men_kept", 1'b0, 1'b1, 64'h1);

        doWrite(12'h320, 64'h1, 2'd3, "inh_cy", 1'b0, 1'b1, 1'b1, 64'd0);
        doWrite(12'hB00, 64'h55, 2'd3, "mcycle_55", 1'b0, 1'b1, 1'b0, 64'd0);
        doRead(12'hC00, 2'd0, "u_cycle_noscen", 1'b1, 1'b1, 64'd0);
        doWrite(12'h106, 64'h1, 2'd1, "scen_1", 1'b0, 1'b1, 1'b1, 64'd0);
        doRead(12'hC00, 2'd0, "u_cycle_ok", 1'b0, 1'b1, 64'h55);
        doRead(12'hC02, 2'd1, "s_instret_noen", 1'b1, 1'b1, 64'd0);
        doRead(12'hC02, 2'd3, "m_instret_alias", 1'b0, 1'b1, 64'd3);
        doRead(12'h106, 2'd0, "u_scen", 1'b1, 1'b1, 64'd0);
        doRead(12'h106, 2'd1, "s_scen", 1'b0, 1'b1, 64'h1);
        doRead(12'h306, 2'd1, "s_men", 1'b1, 1'b1, 64'd0);
        doWrite(12'hC00, 64'h9, 2'd3, "wr_cycle_ro", 1'b1, 1'b1, 1'b1, 64'd0);
        doRead(12'hB00, 2'd3, "mcycle_kept", 1'b0, 1'b1, 64'h55);

        pulseEvents(2, 1'b0, 1'b1, '0);
        doRead(12'hC01, 2'd3, "time_2", 1'b0, 1'b1, 64'd2);
        doWrite(12'hC02, 64'h99, 2'd3, "wr_instret_ro", 1'b1, 1'b1, 1'b1, 64'd0);
        doRead(12'hB02, 2'd3, "minstret_kept", 1'b0, 1'b1, 64'd3);
        doRead(12'hB05, 2'd3, "b05_nohpm", 1'b1, 1'b0, 64'd0);
        doRead(12'hC05, 2'd3, "c05_nohpm", 1'b1, 1'b0, 64'd0);
        doRead(12'hB04, 2'd3, "hpm4_0", 1'b0, 1'b1, 64'd0);

        instr_retired = 1'b1;
        doWrite(12'hB02, 64'h20, 2'd3, "minstret_coll", 1'b0, 1'b1, 1'b1, 64'd3);
        instr_retired = 1'b0;
        doRead(12'hB02, 2'd3, "minstret_20", 1'b0, 1'b1, 64'h20);
        pulseEvents(1, 1'b1, 1'b0, '0);
        doRead(12'hB02, 2'd3, "minstret_21", 1'b0, 1'b1, 64'h21);

        pulseEvents(4, 1'b0, 1'b0, 2'b10);
        pulseEvents(2, 1'b0, 1'b0, 2'b01);
        doRead(12'hC04, 2'd3, "hpm4_4", 1'b0, 1'b1, 64'd4);
        doRead(12'hB03, 2'd3, "hpm3_2", 1'b0, 1'b1, 64'd2);
        doWrite(12'h320, 64'h9, 2'd3, "inh_hpm3", 1'b0, 1'b1, 1'b1, 64'h1);
        pulseEvents(3, 1'b0, 1'b0, 2'b01);
        doRead(12'hB03, 2'd3, "hpm3_inhib", 1'b0, 1'b1, 64'd2);
        doWrite(12'h320, 64'h0, 2'd3, "inh_clr2", 1'b0, 1'b1, 1'b1, 64'h9);

        doWrite(12'hB00, 64'hFF, 2'd3, "mcycle_ff", 1'b0, 1'b1, 1'b0, 64'd0);
        doRead(12'hB00, 2'd3, "mcycle_ff_rd", 1'b0, 1'b1, 64'hFF);
        doRead(12'hB00, 2'd3, "mcycle_100", 1'b0, 1'b1, 64'h100);
        doWrite(12'hB00, 64'hFFFF, 2'd3, "mcycle_max", 1'b0, 1'b1, 1'b0, 64'd0);
        doRead(12'hB00, 2'd3, "mcycle_max_rd", 1'b0, 1'b1, 64'hFFFF);
        doRead(12'hB00, 2'd3, "mcycle_wrap", 1'b0, 1'b1, 64'h0);
        doWrite(12'hB00, 64'h12345, 2'd3, "mcycle_wide", 1'b0, 1'b1, 1'b0, 64'd0);
        doRead(12'hB00, 2'd3, "mcycle_trunc", 1'b0, 1'b1, 64'h2345);
        doWrite(12'hB00, 64'h10, 2'd3, "mcycle_10h", 1'b0, 1'b1, 1'b0, 64'd0);
        doWrite(12'h320, 64'h1, 2'd3, "inh_late", 1'b0, 1'b1, 1'b1, 64'd0);
        doRead(12'hB00, 2'd3, "mcycle_11", 1'b0, 1'b1, 64'h11);
        doRead(12'hB00, 2'd3, "mcycle_hold", 1'b0, 1'b1, 64'h11);
        doWrite(12'h320, 64'h0, 2'd3, "inh_clr3", 1'b0, 1'b1, 1'b1, 64'h1);

`ifdef CSR_COUNTER_OVF_EN
        doWrite(12'hB03, 64'hFFFF, 2'd3, "hpm3_max", 1'b0, 1'b1, 1'b1, 64'd2);
        pulseEvents(1, 1'b0, 1'b0, 2'b01);
        doRead(12'hB03, 2'd3, "hpm3_wrap", 1'b0, 1'b1, 64'd0);
        doReadIrq(12'hDA0, 2'd1, "scountovf_set", 64'h8, 1'b1);
        doWrite(12'hDA0, 64'h0, 2'd3, "scountovf_ro", 1'b1, 1'b1, 1'b1, 64'd0);
        doRead(12'hDA0, 2'd0, "scountovf_u", 1'b1, 1'b1, 64'd0);
        applyStimulus(1'b0, 1'b1, 12'hB03, 64'h0, 2'd3, "hpm3_clr", 1'b0, 1'b1, 1'b1, 64'd0, 1'b1, 1'b1);
        doRead(12'hDA0, 2'd3, "scountovf_clr", 1'b0, 1'b1, 64'd0);
        pulseEvents(1, 1'b0, 1'b0, '0);
        doReadIrq(12'h306, 2'd3, "irq_drop", 64'h1, 1'b0);
        doWrite(12'hB03, 64'hFFFF, 2'd3, "hpm3_max2", 1'b0, 1'b1, 1'b1, 64'd0);
        hpm_event = 2'b01;
        doWrite(12'hB03, 64'h5, 2'd3, "hpm3_wrcoll", 1'b0, 1'b1, 1'b1, 64'hFFFF);
        hpm_event = '0;
        doRead(12'hDA0, 2'd3, "scountovf_coll", 1'b0, 1'b1, 64'd0);
        doRead(12'hB03, 2'd3, "hpm3_5", 1'b0, 1'b1, 64'd5);
`else
        doReadIrq(12'hB04, 2'd3, "irq_tied", 64'd4, 1'b0);
`endif

        for (int i = 0; i < 20 && expq.size() != 0; i++) @(posedge clk);
        if (expq.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: got %0d pending expected 0", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
